// File: rtl/ray_pkg.sv
// Shared types and constants for the ray pipeline: FSM state encoding,
// dimension width and default colour settings.
package ray_pkg;

  localparam int DIM_W = 13;
  localparam int CNT_W = 2 * DIM_W;
  localparam int DEF_COLOR_W = 24;
  localparam logic [DEF_COLOR_W-1:0] DEF_BG_COLOR = 24'h000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } pixel_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy counter and flush; the head word is
// presented combinationally from the storage array.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage array; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ray_pixel_writer.sv
// Pixel writer: accepts shaded ray results in row-major order, buffers them
// and writes each one to base + y*W + x through a request/ack memory port.
module ray_pixel_writer
  import ray_pkg::*;
#(
  parameter int                 COLOR_W    = DEF_COLOR_W,
  parameter int                 ADDR_W     = 26,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR   = DEF_BG_COLOR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   image_width,
  input  logic [DIM_W-1:0]   image_height,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_hit,
  input  logic [COLOR_W-1:0] in_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               frame_done,
  output logic [DIM_W-1:0]   pixel_x,
  output logic [DIM_W-1:0]   pixel_y,
  output logic               protocol_err
);

  pixel_state_t       state_r;
  logic [DIM_W-1:0]   width_r;
  logic [ADDR_W-1:0]  base_r;
  logic [CNT_W-1:0]   total_r;
  logic [CNT_W-1:0]   accept_cnt_r;
  logic [CNT_W-1:0]   write_cnt_r;
  logic [DIM_W-1:0]   x_r;
  logic [DIM_W-1:0]   y_r;
  logic               protocol_err_r;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [COLOR_W-1:0] fifo_head_s;
  logic [COLOR_W-1:0] push_data_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic               dims_ok_s;
  logic               last_pop_s;

  assign push_s      = in_valid && in_ready;
  assign pop_s       = mem_we && mem_ack;
  assign push_data_s = in_hit ? in_color : BG_COLOR;
  assign flush_s     = (state_r == IDLE) && start;
  assign dims_ok_s   = (image_width != {DIM_W{1'b0}}) && (image_height != {DIM_W{1'b0}});
  assign last_pop_s  = pop_s && ((write_cnt_r + CNT_W'(1)) == total_r);

  assign busy         = (state_r != IDLE);
  assign frame_done   = (state_r == DONE);
  assign pixel_x      = x_r;
  assign pixel_y      = y_r;
  assign protocol_err = protocol_err_r;

  pixel_fifo #(
    .WIDTH (COLOR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush_s),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (push_data_s),
    .rdata   (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Backpressure and write-port drive; address and data are zero whenever no request is pending.
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {COLOR_W{1'b0}};
    if ((state_r == ACCEPT) && !fifo_full_s && (accept_cnt_r < total_r)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    if (((state_r == ACCEPT) || (state_r == DRAIN)) && !fifo_empty_s) begin
      mem_we    = 1'b1;
      mem_addr  = base_r + ADDR_W'(write_cnt_r);
      mem_wdata = fifo_head_s;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {COLOR_W{1'b0}};
    end
  end

  // Frame FSM plus accept/write counters and the (x, y) raster position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      width_r        <= {DIM_W{1'b0}};
      base_r         <= {ADDR_W{1'b0}};
      total_r        <= {CNT_W{1'b0}};
      accept_cnt_r   <= {CNT_W{1'b0}};
      write_cnt_r    <= {CNT_W{1'b0}};
      x_r            <= {DIM_W{1'b0}};
      y_r            <= {DIM_W{1'b0}};
      protocol_err_r <= 1'b0;
    end else begin
      if (pop_s) begin
        write_cnt_r <= write_cnt_r + CNT_W'(1);
        if (x_r == (width_r - DIM_W'(1))) begin
          x_r <= {DIM_W{1'b0}};
          y_r <= y_r + DIM_W'(1);
        end else begin
          x_r <= x_r + DIM_W'(1);
        end
      end
      case (state_r)
        IDLE: begin
          if (start && dims_ok_s) begin
            width_r        <= image_width;
            base_r         <= base_addr;
            total_r        <= CNT_W'(image_width) * CNT_W'(image_height);
            accept_cnt_r   <= {CNT_W{1'b0}};
            write_cnt_r    <= {CNT_W{1'b0}};
            x_r            <= {DIM_W{1'b0}};
            y_r            <= {DIM_W{1'b0}};
            protocol_err_r <= 1'b0;
            state_r        <= ACCEPT;
          end else if (start) begin
            state_r <= DONE;
          end else if (in_valid) begin
            protocol_err_r <= 1'b1;
          end
        end
        ACCEPT: begin
          if (push_s) begin
            accept_cnt_r <= accept_cnt_r + CNT_W'(1);
            if ((accept_cnt_r + CNT_W'(1)) == total_r) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Look ahead on the final ack so frame_done follows it by one cycle.
          if (last_pop_s || ((write_cnt_r == total_r) && fifo_empty_s)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
